id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/riscv_pkg.sv | 41 ++++
 rtl/id_ex_stage_forward_mux.sv | 32 +++
 rtl/id_ex_stage.sv | 118 +++++++++++
 tb/tb_id_ex_stage.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: ALU select codes, result-source codes,
// the zero register index and the ID/EX pipeline register bundle.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011
    } alu_op_e;

    localparam logic [1:0] RESULT_SRC_ALU  = 2'b00;
    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    typedef struct packed {
        logic                  valid;
        logic                  illegal;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       rd1;
        logic [XLEN-1:0]       rd2;
        logic [XLEN-1:0]       imm;
        logic [2:0]            alu_ctrl;
        logic                  alu_src;
        logic                  reg_write;
        logic [1:0]            result_src;
        logic                  mem_write;
    } id_ex_regs_t;

    // Only the four codes with bit 2 clear are implemented by the ALU.
    function automatic logic is_illegal_alu(input logic [2:0] ctrl);
        return ctrl[2];
    endfunction

endpackage

// File: rtl/id_ex_stage_forward_mux.sv
// Operand forwarding select: memory stage beats writeback, which beats the
// registered read data; register 0 is never forwarded.
module forward_mux
    import riscv_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [XLEN-1:0]       reg_data,
    input  logic [REG_ADDR_W-1:0] rd_m,
    input  logic                  reg_write_m,
    input  logic [XLEN-1:0]       result_m,
    input  logic [REG_ADDR_W-1:0] rd_w,
    input  logic                  reg_write_w,
    input  logic [XLEN-1:0]       result_w,
    output logic [XLEN-1:0]       operand
);

    logic hit_m;
    logic hit_w;

    assign hit_m = (rs != REG_ZERO) && reg_write_m && (rd_m == rs);
    assign hit_w = (rs != REG_ZERO) && reg_write_w && (rd_w == rs);

    always_comb begin
        operand = reg_data;
        if (hit_m) begin
            operand = result_m;
        end else if (hit_w) begin
            operand = result_w;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall detection, bubble insertion,
// illegal-ALU-op flagging and combinational operand forwarding.
module id_ex_stage
    import riscv_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  valid_d,
    input  logic [REG_ADDR_W-1:0] rs1_d,
    input  logic [REG_ADDR_W-1:0] rs2_d,
    input  logic [REG_ADDR_W-1:0] rd_d,
    input  logic [XLEN-1:0]       rd1_d,
    input  logic [XLEN-1:0]       rd2_d,
    input  logic [XLEN-1:0]       imm_ext_d,
    input  logic [2:0]            alu_ctrl_d,
    input  logic                  alu_src_d,
    input  logic                  reg_write_d,
    input  logic [1:0]            result_src_d,
    input  logic                  mem_write_d,

    input  logic                  flush_e,
    input  logic [REG_ADDR_W-1:0] rd_m,
    input  logic                  reg_write_m,
    input  logic [XLEN-1:0]       alu_result_m,
    input  logic [REG_ADDR_W-1:0] rd_w,
    input  logic                  reg_write_w,
    input  logic [XLEN-1:0]       result_w,

    output logic [XLEN-1:0]       alu_a_e,
    output logic [XLEN-1:0]       alu_b_e,
    output logic [2:0]            alu_ctrl_e,
    output logic [XLEN-1:0]       write_data_e,
    output logic [REG_ADDR_W-1:0] rd_e,
    output logic                  reg_write_e,
    output logic                  mem_write_e,
    output logic [1:0]            result_src_e,
    output logic                  valid_e,
    output logic                  illegal_e,
    output logic                  stall_d
);

    id_ex_regs_t ex_d;
    id_ex_regs_t ex_q;

    logic illegal_d;
    logic bubble;
    logic load_in_e;

    // A load in E cannot supply its data in time for a dependent instruction in D.
    assign load_in_e = ex_q.valid && (ex_q.result_src == RESULT_SRC_LOAD) && (ex_q.rd != REG_ZERO);
    assign stall_d   = load_in_e && valid_d && ((ex_q.rd == rs1_d) || (ex_q.rd == rs2_d));

    assign illegal_d = valid_d && is_illegal_alu(alu_ctrl_d);
    assign bubble    = flush_e || stall_d || !valid_d || illegal_d;

    always_comb begin
        ex_d = '0;
        if (!bubble) begin
            ex_d.valid      = 1'b1;
            ex_d.rs1        = rs1_d;
            ex_d.rs2        = rs2_d;
            ex_d.rd         = rd_d;
            ex_d.rd1        = rd1_d;
            ex_d.rd2        = rd2_d;
            ex_d.imm        = imm_ext_d;
            ex_d.alu_ctrl   = alu_ctrl_d;
            ex_d.alu_src    = alu_src_d;
            ex_d.reg_write  = reg_write_d;
            ex_d.result_src = result_src_d;
            ex_d.mem_write  = mem_write_d;
        end
        // A killed or held instruction is not reported; it is flagged once when it really issues.
        ex_d.illegal = illegal_d && !flush_e && !stall_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    forward_mux u_fwd_a (
        .rs          (ex_q.rs1),
        .reg_data    (ex_q.rd1),
        .rd_m        (rd_m),
        .reg_write_m (reg_write_m),
        .result_m    (alu_result_m),
        .rd_w        (rd_w),
        .reg_write_w (reg_write_w),
        .result_w    (result_w),
        .operand     (alu_a_e)
    );

    forward_mux u_fwd_b (
        .rs          (ex_q.rs2),
        .reg_data    (ex_q.rd2),
        .rd_m        (rd_m),
        .reg_write_m (reg_write_m),
        .result_m    (alu_result_m),
        .rd_w        (rd_w),
        .reg_write_w (reg_write_w),
        .result_w    (result_w),
        .operand     (write_data_e)
    );

    assign alu_b_e      = ex_q.alu_src ? ex_q.imm : write_data_e;
    assign alu_ctrl_e   = ex_q.alu_ctrl;
    assign rd_e         = ex_q.rd;
    assign reg_write_e  = ex_q.reg_write;
    assign mem_write_e  = ex_q.mem_write;
    assign result_src_e = ex_q.result_src;
    assign valid_e      = ex_q.valid;
    assign illegal_e    = ex_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed literal cases followed by a
// randomized run checked against a behavioural pipeline model.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_d;
    logic [4:0]  rs1_d, rs2_d, rd_d;
    logic [31:0] rd1_d, rd2_d, imm_ext_d;
    logic [2:0]  alu_ctrl_d;
    logic        alu_src_d, reg_write_d, mem_write_d;
    logic [1:0]  result_src_d;
    logic        flush_e;
    logic [4:0]  rd_m, rd_w;
    logic        reg_write_m, reg_write_w;
    logic [31:0] alu_result_m, result_w;

    logic [31:0] alu_a_e, alu_b_e, write_data_e;
    logic [2:0]  alu_ctrl_e;
    logic [4:0]  rd_e;
    logic        reg_write_e, mem_write_e, valid_e, illegal_e, stall_d;
    logic [1:0]  result_src_e;

    int total = 0;
    int bad   = 0;

    id_ex_stage dut (
        .clk(clk), .reset(reset),
        .valid_d(valid_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_ext_d(imm_ext_d),
        .alu_ctrl_d(alu_ctrl_d), .alu_src_d(alu_src_d), .reg_write_d(reg_write_d),
        .result_src_d(result_src_d), .mem_write_d(mem_write_d),
        .flush_e(flush_e), .rd_m(rd_m), .reg_write_m(reg_write_m),
        .alu_result_m(alu_result_m), .rd_w(rd_w), .reg_write_w(reg_write_w),
        .result_w(result_w),
        .alu_a_e(alu_a_e), .alu_b_e(alu_b_e), .alu_ctrl_e(alu_ctrl_e),
        .write_data_e(write_data_e), .rd_e(rd_e), .reg_write_e(reg_write_e),
        .mem_write_e(mem_write_e), .result_src_e(result_src_e),
        .valid_e(valid_e), .illegal_e(illegal_e), .stall_d(stall_d)
    );

    always #5 clk = ~clk;

    // Model of the instruction sitting in E (all-zero when E holds nothing).
    logic        m_valid, m_illegal, m_src, m_rw, m_mw;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [31:0] m_rd1, m_rd2, m_imm;
    logic [2:0]  m_ctrl;
    logic [1:0]  m_rsrc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic setIdle();
        valid_d = 0; rs1_d = 0; rs2_d = 0; rd_d = 0; rd1_d = 0; rd2_d = 0; imm_ext_d = 0;
        alu_ctrl_d = 0; alu_src_d = 0; reg_write_d = 0; result_src_d = 0; mem_write_d = 0;
        flush_e = 0; rd_m = 0; reg_write_m = 0; alu_result_m = 0;
        rd_w = 0; reg_write_w = 0; result_w = 0;
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, ".valid_e"}, 32'(valid_e), 0);
        check({tag, ".illegal_e"}, 32'(illegal_e), 0);
        check({tag, ".stall_d"}, 32'(stall_d), 0);
        check({tag, ".rd_e"}, 32'(rd_e), 0);
        check({tag, ".reg_write_e"}, 32'(reg_write_e), 0);
        check({tag, ".mem_write_e"}, 32'(mem_write_e), 0);
        check({tag, ".alu_a_e"}, alu_a_e, 0);
        check({tag, ".alu_b_e"}, alu_b_e, 0);
        check({tag, ".write_data_e"}, write_data_e, 0);
    endtask

    task automatic modelClear();
        m_valid = 0; m_illegal = 0; m_src = 0; m_rw = 0; m_mw = 0;
        m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0;
        m_ctrl = 0; m_rsrc = 0;
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] regval);
        if (rs != 0 && reg_write_m && rd_m == rs) return alu_result_m;
        if (rs != 0 && reg_write_w && rd_w == rs) return result_w;
        return regval;
    endfunction

    function automatic logic modelStall();
        return m_valid && m_rsrc == 2'b01 && m_rd != 0 && valid_d && (m_rd == rs1_d || m_rd == rs2_d);
    endfunction

    // Advance the model by one clock edge using the inputs presented before it.
    task automatic modelUpdate();
        logic stall, illegal, accept;
        stall   = modelStall();
        illegal = valid_d && alu_ctrl_d[2];
        accept  = valid_d && !flush_e && !stall && !illegal;
        modelClear();
        m_illegal = illegal && !flush_e && !stall;
        if (accept) begin
            m_valid = 1; m_rs1 = rs1_d; m_rs2 = rs2_d; m_rd = rd_d;
            m_rd1 = rd1_d; m_rd2 = rd2_d; m_imm = imm_ext_d; m_ctrl = alu_ctrl_d;
            m_src = alu_src_d; m_rw = reg_write_d; m_rsrc = result_src_d; m_mw = mem_write_d;
        end
    endtask

    task automatic checkOutput();
        logic [31:0] b;
        check("stall_d", 32'(stall_d), 32'(modelStall()));
        check("valid_e", 32'(valid_e), 32'(m_valid));
        check("illegal_e", 32'(illegal_e), 32'(m_illegal));
        check("rd_e", 32'(rd_e), 32'(m_rd));
        check("reg_write_e", 32'(reg_write_e), 32'(m_rw));
        check("mem_write_e", 32'(mem_write_e), 32'(m_mw));
        check("result_src_e", 32'(result_src_e), 32'(m_rsrc));
        check("alu_ctrl_e", 32'(alu_ctrl_e), 32'(m_ctrl));
        if (m_valid) begin
            b = fwd(m_rs2, m_rd2);
            check("alu_a_e", alu_a_e, fwd(m_rs1, m_rd1));
            check("write_data_e", write_data_e, b);
            check("alu_b_e", alu_b_e, m_src ? m_imm : b);
        end
    endtask

    task automatic applyStimulus();
        valid_d      = ($urandom_range(0, 9) != 0);
        rs1_d        = 5'($urandom_range(0, 7));
        rs2_d        = 5'($urandom_range(0, 7));
        rd_d         = 5'($urandom_range(0, 7));
        rd1_d        = $urandom;
        rd2_d        = $urandom;
        imm_ext_d    = $urandom;
        alu_ctrl_d   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
        alu_src_d    = 1'($urandom_range(0, 1));
        reg_write_d  = 1'($urandom_range(0, 1));
        result_src_d = 2'($urandom_range(0, 2));
        mem_write_d  = 1'($urandom_range(0, 1));
        flush_e      = ($urandom_range(0, 9) == 0);
        rd_m         = 5'($urandom_range(0, 7));
        reg_write_m  = 1'($urandom_range(0, 1));
        alu_result_m = $urandom;
        rd_w         = 5'($urandom_range(0, 7));
        reg_write_w  = 1'($urandom_range(0, 1));
        result_w     = $urandom;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        setIdle();
        reset = 1;
        #12;
        checkAllZero("in_reset");
        @(negedge clk);
        reset = 0;
        #1;
        checkAllZero("after_reset");

        // Basic pass-through
        valid_d = 1; rs1_d = 1; rs2_d = 2; rd_d = 3; rd1_d = 5; rd2_d = 7; reg_write_d = 1;
        tick();
        check("pt.alu_a_e", alu_a_e, 32'd5);
        check("pt.alu_b_e", alu_b_e, 32'd7);
        check("pt.alu_ctrl_e", 32'(alu_ctrl_e), 0);
        check("pt.valid_e", 32'(valid_e), 1);

        // Forwarding priority on operand A
        rs1_d = 3; rd1_d = 32'h99;
        tick();
        rd_m = 3; reg_write_m = 1; alu_result_m = 32'h11;
        rd_w = 3; reg_write_w = 1; result_w = 32'h22;
        #1 check("fwd.m_wins", alu_a_e, 32'h11);
        reg_write_m = 0;
        #1 check("fwd.w_only", alu_a_e, 32'h22);
        reg_write_w = 0;
        #1 check("fwd.none", alu_a_e, 32'h99);

        // Register 0 is never forwarded
        rs1_d = 0; rs2_d = 0; rd2_d = 32'h1234;
        tick();
        rd_m = 0; reg_write_m = 1; alu_result_m = 32'hFFFF;
        #1 check("x0.write_data_e", write_data_e, 32'h1234);
        check("x0.alu_b_e", alu_b_e, 32'h1234);
        reg_write_m = 0;

        // Load-use stall, then stall combined with flush
        rs2_d = 0; rd_d = 5; result_src_d = 2'b01;
        tick();
        rs2_d = 5; rd_d = 6; result_src_d = 2'b00;
        #1 check("lu.stall_d", 32'(stall_d), 1);
        tick();
        check("lu.bubble_valid_e", 32'(valid_e), 0);
        check("lu.stall_cleared", 32'(stall_d), 0);
        rs2_d = 0; rd_d = 5; result_src_d = 2'b01;
        tick();
        rs2_d = 5; rd_d = 6; result_src_d = 2'b00; flush_e = 1;
        #1 check("luf.stall_d", 32'(stall_d), 1);
        tick();
        check("luf.valid_e", 32'(valid_e), 0);
        flush_e = 0;
        tick();
        check("luf.single_bubble", 32'(valid_e), 1);
        check("luf.rd_e", 32'(rd_e), 6);

        // Illegal ALU op
        alu_ctrl_d = 3'b101; reg_write_d = 1; rd_d = 7;
        tick();
        check("ill.illegal_e", 32'(illegal_e), 1);
        check("ill.reg_write_e", 32'(reg_write_e), 0);
        check("ill.valid_e", 32'(valid_e), 0);
        alu_ctrl_d = 3'b001;
        tick();
        check("ill.cleared", 32'(illegal_e), 0);
        check("ill.next_valid", 32'(valid_e), 1);

        // Asynchronous reset between edges
        #2 reset = 1;
        #1 checkAllZero("async_reset");
        setIdle();
        reset = 0;

        modelClear();
        @(negedge clk);
        for (int i = 0; i < 3000; i++) begin
            applyStimulus();
            #2;
            checkOutput();
            if ($urandom_range(0, 199) == 0) begin
                reset = 1;
                #1;
                checkAllZero("rand_reset");
                modelClear();
                reset = 0;
            end
            @(posedge clk);
            modelUpdate();
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
